// File: rtl/count_sequence_checker_if.sv
// Observed output bus of the 4-bit up-counter.
// The counter drives it as master; monitors consume it as slave.
interface count_sequence_checker_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] count;
    logic             dut_rst;

    modport master (
        output en,
        output count,
        output dut_rst
    );

    modport slave (
        input en,
        input count,
        input dut_rst
    );
endinterface

// File: rtl/count_sequence_checker.sv
// Passive monitor that locks onto the counter's increment/wrap sequence.
// It flags out-of-sequence values and keeps saturating error and wrap statistics.
module count_sequence_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned LOCK_RUN = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    count_sequence_checker_if.slave   cnt_if,
    input  logic                      clear_i,
    output logic                      locked_o,
    output logic                      err_pulse_o,
    output logic [ERR_W-1:0]          err_count_o,
    output logic [ERR_W-1:0]          wrap_count_o,
    output logic [WIDTH-1:0]          expected_o
);

    typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

    state_e           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0] last_inc;
    logic [3:0]       run_inc;
    logic             match;
    logic             err;
    logic             wrap;
    logic [ERR_W-1:0] err_base;
    logic [ERR_W-1:0] wrap_base;

    assign last_inc = last_q + WIDTH'(1);
    assign run_inc  = run_q + 4'd1;
    assign match    = (cnt_if.count == last_inc);

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        last_d      = last_q;
        exp_d       = exp_q;
        err_pulse_d = 1'b0;
        err         = 1'b0;
        wrap        = 1'b0;

        if (cnt_if.en) begin
            if (cnt_if.dut_rst) begin
                // Counter reset restarts the sequence at 0 without touching lock state.
                last_d = '0;
                exp_d  = WIDTH'(1);
                err    = (state_q == StLocked) && (cnt_if.count != '0);
            end else begin
                last_d = cnt_if.count;
                exp_d  = cnt_if.count + WIDTH'(1);
                unique case (state_q)
                    StUnlocked: begin
                        if (match) begin
                            if (run_inc == 4'(LOCK_RUN)) begin
                                state_d = StLocked;
                                run_d   = '0;
                            end else begin
                                run_d = run_inc;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
                    StLocked: begin
                        if (match) begin
                            wrap = (cnt_if.count == '0);
                        end else begin
                            err     = 1'b1;
                            state_d = StUnlocked;
                            run_d   = '0;
                        end
                    end
                    default: state_d = StUnlocked;
                endcase
            end
        end

        err_pulse_d = err;

        // Clear takes effect first so a coincident event leaves the counter at 1.
        err_base   = clear_i ? '0 : err_cnt_q;
        wrap_base  = clear_i ? '0 : wrap_cnt_q;
        err_cnt_d  = (err && (err_base != '1)) ? err_base + ERR_W'(1) : err_base;
        wrap_cnt_d = (wrap && (wrap_base != '1)) ? wrap_base + ERR_W'(1) : wrap_base;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StUnlocked;
            run_q       <= '0;
            last_q      <= '0;
            exp_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            last_q      <= last_d;
            exp_q       <= exp_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    assign locked_o     = (state_q == StLocked);
    assign err_pulse_o  = err_pulse_q;
    assign err_count_o  = err_cnt_q;
    assign wrap_count_o = wrap_cnt_q;
    assign expected_o   = exp_q;

endmodule
